pma_region_unit: RTL and testbench

//  Runtime-programmable physical-memory-attribute table, successor to the static cached/non-idempotent/execute

---
 rtl/pma_pkg.sv | 21 ++
 rtl/pma_rule_match.sv | 17 +
 rtl/pma_region_unit.sv | 164 ++++++++++++++++
 tb/tb_pma_region_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pma_pkg.sv
// rtl/pma_pkg.sv - shared types and constants for the PMA region table
package pma_pkg;

    typedef struct packed {
        logic lock;
        logic x;
        logic c;
        logic ni;
    } pma_attr_t;

    typedef enum logic [1:0] {
        FIELD_BASE   = 2'd0,
        FIELD_LENGTH = 2'd1,
        FIELD_ATTR   = 2'd2,
        FIELD_RSVD   = 2'd3
    } pma_field_e;

    // Addresses outside every region are treated as uncached, non-executable device space.
    localparam pma_attr_t NO_HIT_ATTR = '{lock: 1'b0, x: 1'b0, c: 1'b0, ni: 1'b1};

endpackage

// File: rtl/pma_rule_match.sv
// rtl/pma_rule_match.sv - single region range comparator
module pma_rule_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] base,
    input  logic [AddrWidth-1:0] length,
    input  logic [AddrWidth-1:0] addr,
    output logic                 match
);

    // One extra bit so a region ending at the top of the address space does not wrap to zero.
    logic [AddrWidth:0] limit;

    assign limit = {1'b0, base} + {1'b0, length};
    assign match = (length != '0) && (addr >= base) && ({1'b0, addr} < limit);

endmodule

// File: rtl/pma_region_unit.sv
// rtl/pma_region_unit.sv - programmable PMA region table with pipelined lookup
module pma_region_unit
    import pma_pkg::*;
#(
    parameter int unsigned                   NrRules   = 4,
    parameter int unsigned                   AddrWidth = 64,
    parameter logic [NrRules*AddrWidth-1:0]  RstBase   = {64'h8000_0000, 64'h1_0000, 64'h0, 64'h0},
    parameter logic [NrRules*AddrWidth-1:0]  RstLength = {64'h4000_0000, 64'h1_0000, 64'h1000, 64'h0},
    parameter logic [NrRules*4-1:0]          RstAttr   = {4'b0110, 4'b0100, 4'b0100, 4'b0000}
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_req_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(NrRules)+1:0]   cfg_addr_i,
    input  logic [AddrWidth-1:0]         cfg_wdata_i,
    output logic [AddrWidth-1:0]         cfg_rdata_o,
    output logic                         cfg_err_o,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [AddrWidth-1:0]         req_addr_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic                         resp_hit_o,
    output logic                         resp_exec_o,
    output logic                         resp_cached_o,
    output logic                         resp_nonidem_o
);

    localparam int unsigned IdxW = $clog2(NrRules);

    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    pma_attr_t            attr_q [NrRules];

    logic [4:0]           cfg_idx;
    pma_field_e           cfg_field;
    logic                 idx_ok;
    logic                 bad_access;
    logic                 sel_locked;
    logic                 wr_en;
    logic                 err_d;
    logic [AddrWidth-1:0] rd_val;

    generate
        if (IdxW > 0) begin : g_idx
            assign cfg_idx = 5'(cfg_addr_i[IdxW+1:2]);
        end else begin : g_idx_single
            assign cfg_idx = '0;
        end
    endgenerate

    assign cfg_field  = pma_field_e'(cfg_addr_i[1:0]);
    assign idx_ok     = ({27'd0, cfg_idx} < NrRules);
    assign bad_access = !idx_ok || (cfg_field == FIELD_RSVD);

    always_comb begin
        rd_val     = '0;
        sel_locked = 1'b0;
        for (int i = 0; i < NrRules; i++) begin
            if (idx_ok && cfg_idx == 5'(i)) begin
                sel_locked = attr_q[i].lock;
                case (cfg_field)
                    FIELD_BASE:   rd_val = base_q[i];
                    FIELD_LENGTH: rd_val = len_q[i];
                    FIELD_ATTR:   rd_val = AddrWidth'(attr_q[i]);
                    default:      rd_val = '0;
                endcase
            end
        end
    end

    assign wr_en = cfg_req_i && cfg_we_i && !bad_access && !sel_locked;
    assign err_d = bad_access || (cfg_we_i && sel_locked);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrRules; i++) begin
                base_q[i] <= RstBase[(NrRules-1-i)*AddrWidth +: AddrWidth];
                len_q[i]  <= RstLength[(NrRules-1-i)*AddrWidth +: AddrWidth];
                attr_q[i] <= pma_attr_t'(RstAttr[(NrRules-1-i)*4 +: 4]);
            end
        end else if (wr_en) begin
            for (int i = 0; i < NrRules; i++) begin
                if (cfg_idx == 5'(i)) begin
                    case (cfg_field)
                        FIELD_BASE:   base_q[i] <= cfg_wdata_i;
                        FIELD_LENGTH: len_q[i]  <= cfg_wdata_i;
                        FIELD_ATTR:   attr_q[i] <= pma_attr_t'(cfg_wdata_i[3:0]);
                        default:      ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rdata_o <= '0;
            cfg_err_o   <= 1'b0;
        end else begin
            cfg_err_o <= cfg_req_i && err_d;
            if (cfg_req_i && !cfg_we_i) begin
                cfg_rdata_o <= rd_val;
            end
        end
    end

    logic [NrRules-1:0] match;

    for (genvar g = 0; g < NrRules; g++) begin : g_rule
        pma_rule_match #(.AddrWidth(AddrWidth)) u_match (
            .base   (base_q[g]),
            .length (len_q[g]),
            .addr   (req_addr_i),
            .match  (match[g])
        );
    end

    logic win_hit;
    logic win_x;
    logic win_c;
    logic win_ni;

    // Scan from the top so the lowest matching index is the last one assigned.
    always_comb begin
        win_hit = 1'b0;
        win_x   = NO_HIT_ATTR.x;
        win_c   = NO_HIT_ATTR.c;
        win_ni  = NO_HIT_ATTR.ni;
        for (int i = NrRules - 1; i >= 0; i--) begin
            if (match[i]) begin
                win_hit = 1'b1;
                win_x   = attr_q[i].x;
                win_c   = attr_q[i].c;
                win_ni  = attr_q[i].ni;
            end
        end
    end

    logic accept;

    assign req_ready_o = !resp_valid_o || resp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_o   <= 1'b0;
            resp_hit_o     <= 1'b0;
            resp_exec_o    <= 1'b0;
            resp_cached_o  <= 1'b0;
            resp_nonidem_o <= 1'b0;
        end else if (accept) begin
            resp_valid_o   <= 1'b1;
            resp_hit_o     <= win_hit;
            resp_exec_o    <= win_x;
            resp_cached_o  <= win_c;
            resp_nonidem_o <= win_ni;
        end else if (resp_ready_i) begin
            resp_valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pma_region_unit.sv
// tb/tb_pma_region_unit.sv - directed self-checking bench for pma_region_unit
module tb_pma_region_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_req = 1'b0;
    logic        cfg_req2 = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [63:0] cfg_wdata = '0;
    logic [63:0] cfg_rdata, cfg_rdata2;
    logic        cfg_err, cfg_err2;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        resp_hit, resp_exec, resp_cached, resp_nonidem;
    logic        req_valid2 = 1'b0;
    logic        resp_ready2 = 1'b1;
    logic        d2_req_ready, d2_resp_valid, d2_hit, d2_exec, d2_cached, d2_nonidem;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pma_region_unit dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_hit_o(resp_hit), .resp_exec_o(resp_exec),
        .resp_cached_o(resp_cached), .resp_nonidem_o(resp_nonidem)
    );

    // Three-rule instance so an out-of-range index is encodable on the cfg address.
    pma_region_unit #(
        .NrRules(3), .AddrWidth(64),
        .RstBase({64'h8000_0000, 64'h1_0000, 64'h3000}),
        .RstLength({64'h100, 64'h100, 64'h100}),
        .RstAttr({4'b0001, 4'b0010, 4'b0100})
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_req_i(cfg_req2), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_rdata_o(cfg_rdata2), .cfg_err_o(cfg_err2),
        .req_valid_i(req_valid2), .req_ready_o(d2_req_ready), .req_addr_i(req_addr),
        .resp_valid_o(d2_resp_valid), .resp_ready_i(resp_ready2),
        .resp_hit_o(d2_hit), .resp_exec_o(d2_exec),
        .resp_cached_o(d2_cached), .resp_nonidem_o(d2_nonidem)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] resp4();
        return 64'({resp_hit, resp_exec, resp_cached, resp_nonidem});
    endfunction

    // Expected value is {hit, exec, cached, nonidem}.
    task automatic lookup(input string tag, input logic [63:0] a, input logic [3:0] exp);
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = a;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_valid"}, 64'(resp_valid), 64'd1);
        check(tag, resp4(), 64'(exp));
    endtask

    task automatic cfg_rd(input bit sel, input int idx, input int fld,
                          output logic [63:0] d, output logic e);
        @(negedge clk);
        cfg_we   = 1'b0;
        cfg_addr = 4'(idx * 4 + fld);
        if (sel) cfg_req2 = 1'b1;
        else     cfg_req  = 1'b1;
        @(negedge clk);
        cfg_req  = 1'b0;
        cfg_req2 = 1'b0;
        d = sel ? cfg_rdata2 : cfg_rdata;
        e = sel ? cfg_err2 : cfg_err;
    endtask

    task automatic cfg_wr(input int idx, input int fld, input logic [63:0] data, output logic e);
        @(negedge clk);
        cfg_req   = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 4'(idx * 4 + fld);
        cfg_wdata = data;
        @(negedge clk);
        cfg_req = 1'b0;
        cfg_we  = 1'b0;
        e = cfg_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic        e;

        repeat (2) @(negedge clk);
        check("rst_rdata", cfg_rdata, 64'd0);
        check("rst_err", 64'(cfg_err), 64'd0);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_resp", resp4(), 64'd0);
        rst_n = 1'b1;

        lookup("lk_rule0", 64'h8000_1000, 4'b1110);
        lookup("lk_miss", 64'h2000_0000, 4'b0001);
        lookup("lk_rule1_top", 64'h1_FFFF, 4'b1100);
        lookup("lk_rule1_end", 64'h2_0000, 4'b0001);
        lookup("lk_rule2_zero", 64'h0, 4'b1100);

        cfg_rd(0, 0, 0, d, e);
        check("rd_base0", d, 64'h8000_0000);
        check("rd_base0_err", 64'(e), 64'd0);
        cfg_rd(0, 1, 2, d, e);
        check("rd_attr1", d, 64'h4);

        cfg_wr(3, 0, 64'hFFFF_FFFF_FFFF_F000, e);
        cfg_wr(3, 1, 64'h2000, e);
        cfg_wr(3, 2, 64'h2, e);
        check("wr_rule3_err", 64'(e), 64'd0);
        lookup("lk_top_last", 64'hFFFF_FFFF_FFFF_FFFF, 4'b1010);
        lookup("lk_top_base", 64'hFFFF_FFFF_FFFF_F000, 4'b1010);
        lookup("lk_nowrap_zero", 64'h0, 4'b1100);
        lookup("lk_nowrap_1000", 64'h1000, 4'b0001);

        cfg_wr(3, 0, 64'h8000_0000, e);
        cfg_wr(3, 1, 64'h1000, e);
        cfg_wr(3, 2, 64'h1, e);
        lookup("lk_overlap", 64'h8000_0800, 4'b1110);
        lookup("lk_below0", 64'h7FFF_FFFF, 4'b0001);

        cfg_wr(1, 2, 64'hC, e);
        check("lock_wr_err", 64'(e), 64'd0);
        cfg_rd(0, 1, 2, d, e);
        check("lock_attr_rd", d, 64'hC);
        cfg_wr(1, 0, 64'h5000, e);
        check("locked_wr_err", 64'(e), 64'd1);
        @(negedge clk);
        check("err_clears", 64'(cfg_err), 64'd0);
        cfg_rd(0, 1, 0, d, e);
        check("locked_base_rd", d, 64'h1_0000);
        check("locked_rd_err", 64'(e), 64'd0);
        cfg_wr(1, 2, 64'h0, e);
        check("locked_attr_err", 64'(e), 64'd1);
        lookup("lk_locked", 64'h1_8000, 4'b1100);

        // Backpressure: A accepted, held for three stalled cycles while B waits.
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 64'h1_0000;
        @(negedge clk);
        req_addr = 64'h2000_0000;
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_hold", resp4(), 64'hC);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_ready_release", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_second_valid", 64'(resp_valid), 64'd1);
        check("bp_second", resp4(), 64'h1);
        @(negedge clk);
        check("bp_drained", 64'(resp_valid), 64'd0);

        cfg_wr(3, 1, 64'h0, e);
        @(negedge clk);
        cfg_req   = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 4'(0 * 4 + 1);
        cfg_wdata = 64'h0;
        req_valid = 1'b1;
        req_addr  = 64'h8000_0000;
        @(negedge clk);
        cfg_req   = 1'b0;
        cfg_we    = 1'b0;
        req_valid = 1'b0;
        check("same_cycle_old", resp4(), 64'hE);
        lookup("same_cycle_new", 64'h8000_0000, 4'b0001);

        cfg_rd(0, 2, 3, d, e);
        check("rsvd_rd_data", d, 64'd0);
        check("rsvd_rd_err", 64'(e), 64'd1);
        cfg_wr(2, 3, 64'h55, e);
        check("rsvd_wr_err", 64'(e), 64'd1);
        cfg_rd(1, 2, 0, d, e);
        check("r3_base2", d, 64'h3000);
        cfg_rd(1, 3, 0, d, e);
        check("r3_badidx_data", d, 64'd0);
        check("r3_badidx_err", 64'(e), 64'd1);

        // Async reset while a result is stalled.
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 64'h8000_1000;
        @(negedge clk);
        req_valid = 1'b0;
        check("arst_pre_valid", 64'(resp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(resp_valid), 64'd0);
        check("arst_resp", resp4(), 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        cfg_rd(0, 1, 2, d, e);
        check("arst_unlock_attr", d, 64'h4);
        cfg_wr(1, 0, 64'h5000, e);
        check("arst_unlock_wr", 64'(e), 64'd0);
        cfg_rd(0, 0, 1, d, e);
        check("arst_len0", d, 64'h4000_0000);
        lookup("arst_lk_rule0", 64'h8000_1000, 4'b1110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
